// File: rtl/axil_arbiter_2x1.sv
// axil_arbiter_2x1
//
// Two-master to one-slave AXI-Lite arbiter for the nano_rv32i core.
// Master 0 is the instruction fetch unit, master 1 the load/store unit.
// One complete transaction (address, data and response) is owned by one
// master at a time. After each completion the arbiter spends one cycle in
// IDLE before it grants again.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests are resolved
//                         by a 1-bit pointer that moves to the non-owner on
//                         every completion (reset value selects master 0).
//                         When undefined, master 1 always wins a tie.
//
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   mN_aw*/mN_w*/mN_b*  (N=0,1)     master write address/data/response
//   mN_ar*/mN_r*        (N=0,1)     master read address/data
//   s_aw*/s_w*/s_b*                 slave write address/data/response
//   s_ar*/s_r*                      slave read address/data
//   grant_o                         one-hot owner {m1,m0}, 2'b00 when idle
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; pick master and operation, slave sees nothing
// WRITE | owner's AW/W/B routed to slave; leaves on B handshake
// READ  | owner's AR/R routed to slave; leaves on R handshake

module axil_arbiter_2x1 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,

   input  logic [ADDR_W-1:0] m0_awaddr_i,
   input  logic              m0_awvalid_i,
   output logic              m0_awready_o,
   input  logic [DATA_W-1:0] m0_wdata_i,
   input  logic              m0_wvalid_i,
   output logic              m0_wready_o,
   output logic              m0_bvalid_o,
   input  logic              m0_bready_i,
   input  logic [ADDR_W-1:0] m0_araddr_i,
   input  logic              m0_arvalid_i,
   output logic              m0_arready_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_rvalid_o,
   input  logic              m0_rready_i,

   input  logic [ADDR_W-1:0] m1_awaddr_i,
   input  logic              m1_awvalid_i,
   output logic              m1_awready_o,
   input  logic [DATA_W-1:0] m1_wdata_i,
   input  logic              m1_wvalid_i,
   output logic              m1_wready_o,
   output logic              m1_bvalid_o,
   input  logic              m1_bready_i,
   input  logic [ADDR_W-1:0] m1_araddr_i,
   input  logic              m1_arvalid_i,
   output logic              m1_arready_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_rvalid_o,
   input  logic              m1_rready_i,

   output logic [ADDR_W-1:0] s_awaddr_o,
   output logic              s_awvalid_o,
   input  logic              s_awready_i,
   output logic [DATA_W-1:0] s_wdata_o,
   output logic              s_wvalid_o,
   input  logic              s_wready_i,
   input  logic              s_bvalid_i,
   output logic              s_bready_o,
   output logic [ADDR_W-1:0] s_araddr_o,
   output logic              s_arvalid_o,
   input  logic              s_arready_i,
   input  logic [DATA_W-1:0] s_rdata_i,
   input  logic              s_rvalid_i,
   output logic              s_rready_o,

   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      READ  = 2'b10
   } state_t;

   state_t     state;
   logic       owner;
   logic [1:0] grant_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic       prio;
`endif

   logic wreq0, wreq1, req0, req1;
   logic pick, pick_wr;
   logic in_wr, in_rd;
   logic own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
   logic wr_done, rd_done;

   assign wreq0 = m0_awvalid_i | m0_wvalid_i;
   assign wreq1 = m1_awvalid_i | m1_wvalid_i;
   assign req0  = wreq0 | m0_arvalid_i;
   assign req1  = wreq1 | m1_arvalid_i;

   // pick is only consumed when at least one master requests, so a lone
   // master 0 request resolves to 0 through req1 being low.
`ifdef ARB_ROUND_ROBIN_EN
   assign pick = (req0 & req1) ? prio : req1;
`else
   assign pick = req1;
`endif
   // A master with both write and read pending is served write first.
   assign pick_wr = pick ? wreq1 : wreq0;

   assign in_wr = (state == WRITE);
   assign in_rd = (state == READ);

   assign own_awvalid = owner ? m1_awvalid_i : m0_awvalid_i;
   assign own_wvalid  = owner ? m1_wvalid_i  : m0_wvalid_i;
   assign own_bready  = owner ? m1_bready_i  : m0_bready_i;
   assign own_arvalid = owner ? m1_arvalid_i : m0_arvalid_i;
   assign own_rready  = owner ? m1_rready_i  : m0_rready_i;

   assign wr_done = in_wr & s_bvalid_i & own_bready;
   assign rd_done = in_rd & s_rvalid_i & own_rready;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         owner   <= 1'b0;
         grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         prio    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner   <= pick;
                  state   <= pick_wr ? WRITE : READ;
                  grant_q <= pick ? 2'b10 : 2'b01;
               end
            end
            WRITE: begin
               if (wr_done) begin
                  state   <= IDLE;
                  grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                  prio    <= ~owner;
`endif
               end
            end
            READ: begin
               if (rd_done) begin
                  state   <= IDLE;
                  grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                  prio    <= ~owner;
`endif
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign grant_o = grant_q;

   // Address/data buses follow the owner unconditionally; only the
   // handshake signals are gated by state.
   assign s_awaddr_o  = owner ? m1_awaddr_i : m0_awaddr_i;
   assign s_wdata_o   = owner ? m1_wdata_i  : m0_wdata_i;
   assign s_araddr_o  = owner ? m1_araddr_i : m0_araddr_i;

   assign s_awvalid_o = in_wr & own_awvalid;
   assign s_wvalid_o  = in_wr & own_wvalid;
   assign s_bready_o  = in_wr & own_bready;
   assign s_arvalid_o = in_rd & own_arvalid;
   assign s_rready_o  = in_rd & own_rready;

   assign m0_awready_o = in_wr & ~owner & s_awready_i;
   assign m0_wready_o  = in_wr & ~owner & s_wready_i;
   assign m0_bvalid_o  = in_wr & ~owner & s_bvalid_i;
   assign m0_arready_o = in_rd & ~owner & s_arready_i;
   assign m0_rvalid_o  = in_rd & ~owner & s_rvalid_i;

   assign m1_awready_o = in_wr & owner & s_awready_i;
   assign m1_wready_o  = in_wr & owner & s_wready_i;
   assign m1_bvalid_o  = in_wr & owner & s_bvalid_i;
   assign m1_arready_o = in_rd & owner & s_arready_i;
   assign m1_rvalid_o  = in_rd & owner & s_rvalid_i;

   assign m0_rdata_o = s_rdata_i;
   assign m1_rdata_o = s_rdata_i;

endmodule

// File: doc/axil_arbiter_2x1.md
Name: axil_arbiter_2x1

Overview:
- Two-master to one-slave AXI-Lite arbiter for the nano_rv32i core.
- Master 0 is the instruction fetch unit; master 1 is the load/store unit. The slave port drives the shared memory/peripheral bus.
- Grants exactly one complete transaction at a time: address and data phases through the response.
- Drops the master's channels back to idle when that transaction completes.

Parameters:
ADDR_W, 32, address width of all AW/AR channels
DATA_W, 32, data width of all W/R channels

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  reset, asynchronous, active-low
mN_awaddr_i / mN_araddr_i (N=0,1)  in  ADDR_W each  master write/read address
mN_awvalid_i, mN_wvalid_i, mN_arvalid_i  in  1 each  master request valids
mN_awready_o, mN_wready_o, mN_arready_o  out  1 each  readies returned to master
mN_wdata_i  in  DATA_W  master write data
mN_bvalid_o, mN_rvalid_o  out  1 each  responses to master
mN_bready_i, mN_rready_i  in  1 each  master response readies
mN_rdata_o  out  DATA_W  read data to master
s_awaddr_o, s_araddr_o  out  ADDR_W each  slave addresses
s_awvalid_o, s_wvalid_o, s_arvalid_o  out  1 each  slave request valids
s_awready_i, s_wready_i, s_arready_i  in  1 each  slave readies
s_wdata_o  out  DATA_W  slave write data
s_bvalid_i, s_rvalid_i  in  1 each  slave responses
s_bready_o, s_rready_o  out  1 each  slave response readies
s_rdata_i  in  DATA_W  slave read data
grant_o  out  2  one-hot owner {m1,m0}; 2'b00 when idle

Behaviour:
- Registered state: IDLE, WRITE, READ.
- Registered owner bit selects the master; grant_o is derived from state and owner.
- Reset (async): state=IDLE, owner=0, priority pointer=0.
- During reset, every *_valid_o, *_ready_o and grant_o is 0. Address/data outputs are don't-care; driving 0 is acceptable.
- Request of master N: wreq_N = mN_awvalid_i | mN_wvalid_i; rreq_N = mN_arvalid_i.
- IDLE, master select:
  - Only one master requesting: that master is chosen.
  - Both requesting, default: master 1 (LSU) wins (fixed priority).
- IDLE, operation select for the chosen master: write if wreq, else read. Write beats read from the same master.
- IDLE registers state and owner. The slave sees nothing in the IDLE cycle: 1-cycle arbitration latency.
- WRITE:
  - Combinationally forward owner's awaddr/awvalid/wdata/wvalid to the slave, and slave awready/wready/bvalid to the owner.
  - Owner's bready goes to s_bready_o.
  - AR/R channels of both masters and the slave are held at valid/ready 0.
  - Exit to IDLE on the clock edge where s_bvalid_i & owner bready.
- READ:
  - Same routing for the AR/R channels.
  - Exit to IDLE on s_rvalid_i & owner rready.
- The non-owner always sees all readies and response valids at 0. Its requests wait, unmodified per AXI rules.
- AW and W may be accepted by the slave in either order or together. The arbiter never re-asserts a channel; it only gates the master's own valids.
- Response data/addresses are muxed by owner. mN_rdata_o may be driven with s_rdata_i for both masters; only rvalid is gated.
- No timeout: a slave that never responds holds the grant until reset.
- Reset mid-transaction: immediate return to IDLE with all valids 0. The slave is assumed reset together.
- Back-to-back: the completion cycle returns to IDLE, and arbitration happens the following cycle. Minimum 1 idle cycle between transactions.
- Illegal state encoding recovers to IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit priority pointer toggles to the non-owner on each transaction completion.
  - On simultaneous requests in IDLE, the master indicated by the pointer wins.
  - Reset pointer = 0, so master 0 has first priority.
- When undefined: fixed priority with master 1 always winning; no pointer register exists.

Test Plan:
- Single read from m0 (araddr=0x0000_0010), slave arready after 2 cycles, rdata=0xDEAD_BEEF → grant_o=01 one cycle after arvalid; m0_rdata_o=0xDEAD_BEEF with m0_rvalid_o=1; back to IDLE; grant_o=00.
- m1 write addr=0x100, data=0x1234_5678; slave accepts W one cycle before AW, bvalid 3 cycles later → s_wdata_o=0x1234_5678; m1_bvalid_o pulses once; m0 channels are never asserted.
- m0 read and m1 write requested in the same cycle, macro off → m1 write served first; m0 read starts 1 cycle after m1's B handshake. Repeated 3 times: m1 wins each time.
- Same contention, macro on, both requesting continuously → grants alternate m0,m1,m0,m1.
- m1 asserts awvalid and arvalid together → write completes first, then the read. The AR channel is gated to 0 during the write.
- rst_n_i deasserted low during READ with slave rvalid pending → all outputs 0 asynchronously. After release, grant_o=00 until a new request.
